// File: rtl/tcp_msg_ptr_poller_mq.sv
// Message-pointer poller: pops active flows, fetches request and ring pointers,
// and either emits a message descriptor and clears the flow or requeues it.
module tcp_msg_ptr_poller_mq #(
    parameter int unsigned FLOWID_W        = 8,
    parameter int unsigned POLLER_PTR_W    = 16,
    parameter int unsigned STAT_W          = 32,
    parameter int unsigned XY_WIDTH        = 8,
    parameter int unsigned NOC_FBITS_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       q_empty,
    output logic                       q_rd_en,
    input  logic [FLOWID_W-1:0]        q_rd_data,
    input  logic                       q_full,
    output logic                       q_wr_en,
    output logic [FLOWID_W-1:0]        q_wr_data,

    output logic                       req_mem_rd_req_val,
    input  logic                       req_mem_rd_req_rdy,
    output logic [FLOWID_W-1:0]        req_mem_rd_req_addr,
    input  logic                       req_mem_rd_resp_val,
    input  logic [POLLER_PTR_W-1:0]    req_mem_rd_resp_len,
    input  logic [XY_WIDTH-1:0]        req_mem_rd_resp_dst_x,
    input  logic [XY_WIDTH-1:0]        req_mem_rd_resp_dst_y,
    input  logic [NOC_FBITS_WIDTH-1:0] req_mem_rd_resp_fbits,
    input  logic                       req_mem_rd_resp_mode,

    output logic                       ptr_rd_req_val,
    input  logic                       ptr_rd_req_rdy,
    output logic [FLOWID_W-1:0]        ptr_rd_req_addr,
    input  logic                       ptr_rd_resp_val,
    input  logic [POLLER_PTR_W:0]      ptr_rd_resp_base,
    input  logic [POLLER_PTR_W:0]      ptr_rd_resp_end,

    output logic                       msg_dst_val,
    input  logic                       msg_dst_rdy,
    output logic [FLOWID_W-1:0]        msg_dst_flowid,
    output logic [POLLER_PTR_W:0]      msg_dst_base_ptr,
    output logic [POLLER_PTR_W-1:0]    msg_dst_len,
    output logic [XY_WIDTH-1:0]        msg_dst_dst_x,
    output logic [XY_WIDTH-1:0]        msg_dst_dst_y,
    output logic [NOC_FBITS_WIDTH-1:0] msg_dst_fbits,

    output logic                       clr_val,
    input  logic                       clr_rdy,
    output logic [FLOWID_W-1:0]        clr_flowid,

    output logic [STAT_W-1:0]          stat_polls,
    output logic [STAT_W-1:0]          stat_hits
);

    localparam int unsigned PTR_W = POLLER_PTR_W + 1;
    localparam logic [PTR_W-1:0] BUF_DEPTH = {1'b1, {POLLER_PTR_W{1'b0}}};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ_RD,
        ST_REQ_WAIT,
        ST_PTR_RD,
        ST_PTR_WAIT,
        ST_EVAL,
        ST_SEND,
        ST_CLEAR,
        ST_REQUEUE
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_q_rd_en;
    logic                       w_q_wr_en;

    logic [FLOWID_W-1:0]        r_flowid;
    logic [POLLER_PTR_W-1:0]    r_len;
    logic [XY_WIDTH-1:0]        r_dst_x;
    logic [XY_WIDTH-1:0]        r_dst_y;
    logic [NOC_FBITS_WIDTH-1:0] r_fbits;
    logic                       r_mode;
    logic [PTR_W-1:0]           r_base;
    logic [PTR_W-1:0]           r_end;
    logic [STAT_W-1:0]          r_stat_polls;
    logic [STAT_W-1:0]          r_stat_hits;

    logic                       r_req_val;
    logic                       r_ptr_val;
    logic                       r_msg_val;
    logic                       r_clr_val;

    logic [PTR_W-1:0]           w_used_data;
    logic [PTR_W-1:0]           w_used_space;
    logic [PTR_W-1:0]           w_room;
    logic [PTR_W-1:0]           w_len_ext;
    logic                       w_satisfied;

    // Ring occupancy, all modulo 2^PTR_W; the wrap bit makes full distinguishable from empty
    assign w_used_data  = r_end - r_base;
    assign w_used_space = r_base - r_end;
    assign w_room       = BUF_DEPTH - w_used_space;
    assign w_len_ext    = {1'b0, r_len};
    assign w_satisfied  = (r_len == '0) ||
                          (r_mode ? (w_room >= w_len_ext) : (w_used_data >= w_len_ext));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_q_rd_en    = 1'b0;
        w_q_wr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst && !q_empty) begin
                    w_q_rd_en    = 1'b1;
                    w_state_next = ST_REQ_RD;
                end
            end
            ST_REQ_RD: begin
                if (req_mem_rd_req_rdy) w_state_next = ST_REQ_WAIT;
            end
            ST_REQ_WAIT: begin
                if (req_mem_rd_resp_val) w_state_next = ST_PTR_RD;
            end
            ST_PTR_RD: begin
                if (ptr_rd_req_rdy) w_state_next = ST_PTR_WAIT;
            end
            ST_PTR_WAIT: begin
                if (ptr_rd_resp_val) w_state_next = ST_EVAL;
            end
            ST_EVAL: begin
                w_state_next = w_satisfied ? ST_SEND : ST_REQUEUE;
            end
            ST_SEND: begin
                if (msg_dst_rdy) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_rdy) w_state_next = ST_IDLE;
            end
            ST_REQUEUE: begin
                if (!rst && !q_full) begin
                    w_q_wr_en    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Valids are registered images of the next state, so they never follow a rdy input combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_val    <= 1'b0;
            r_ptr_val    <= 1'b0;
            r_msg_val    <= 1'b0;
            r_clr_val    <= 1'b0;
            r_flowid     <= '0;
            r_len        <= '0;
            r_dst_x      <= '0;
            r_dst_y      <= '0;
            r_fbits      <= '0;
            r_mode       <= 1'b0;
            r_base       <= '0;
            r_end        <= '0;
            r_stat_polls <= '0;
            r_stat_hits  <= '0;
        end else begin
            r_req_val <= (w_state_next == ST_REQ_RD);
            r_ptr_val <= (w_state_next == ST_PTR_RD);
            r_msg_val <= (w_state_next == ST_SEND);
            r_clr_val <= (w_state_next == ST_CLEAR);

            if (w_q_rd_en) begin
                r_flowid <= q_rd_data;
            end
            if (r_state == ST_REQ_WAIT && req_mem_rd_resp_val) begin
                r_len   <= req_mem_rd_resp_len;
                r_dst_x <= req_mem_rd_resp_dst_x;
                r_dst_y <= req_mem_rd_resp_dst_y;
                r_fbits <= req_mem_rd_resp_fbits;
                r_mode  <= req_mem_rd_resp_mode;
            end
            if (r_state == ST_PTR_WAIT && ptr_rd_resp_val) begin
                r_base <= ptr_rd_resp_base;
                r_end  <= ptr_rd_resp_end;
            end
            if (r_state == ST_EVAL) begin
                r_stat_polls <= r_stat_polls + STAT_W'(1);
                if (w_satisfied) begin
                    r_stat_hits <= r_stat_hits + STAT_W'(1);
                end
            end
        end
    end

    assign q_rd_en             = w_q_rd_en;
    assign q_wr_en             = w_q_wr_en;
    assign q_wr_data           = r_flowid;
    assign req_mem_rd_req_val  = r_req_val;
    assign req_mem_rd_req_addr = r_flowid;
    assign ptr_rd_req_val      = r_ptr_val;
    assign ptr_rd_req_addr     = r_flowid;
    assign msg_dst_val         = r_msg_val;
    assign msg_dst_flowid      = r_flowid;
    assign msg_dst_base_ptr    = r_base;
    assign msg_dst_len         = r_len;
    assign msg_dst_dst_x       = r_dst_x;
    assign msg_dst_dst_y       = r_dst_y;
    assign msg_dst_fbits       = r_fbits;
    assign clr_val             = r_clr_val;
    assign clr_flowid          = r_flowid;
    assign stat_polls          = r_stat_polls;
    assign stat_hits           = r_stat_hits;

endmodule

// File: doc/tcp_msg_ptr_poller_mq.md
TCP_MSG_PTR_POLLER_MQ -- requirements
Module: tcp_msg_ptr_poller_mq

Interface
REQ-001 Parameter FLOWID_W, default 8, flow-ID width.
REQ-002 Parameter POLLER_PTR_W, default 16, buffer index width; pointers are POLLER_PTR_W+1 bits, with the MSB as the wrap bit.
REQ-003 Parameter STAT_W, default 32, statistics counter width.
REQ-004 Port clk, input, 1, sole clock.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Ports q_empty (input 1), q_rd_en (output 1), q_rd_data (input FLOWID_W): first-word-fall-through active-flow queue, read side.
REQ-007 Ports q_full (input 1), q_wr_en (output 1), q_wr_data (output FLOWID_W): same queue, write side, used for requeue.
REQ-008 Ports req_mem_rd_req_val/rdy (out/in 1) and req_mem_rd_req_addr (out FLOWID_W): request-memory read request.
REQ-009 Request-memory read response ports:
- req_mem_rd_resp_val (in 1)
- req_mem_rd_resp_len (in POLLER_PTR_W)
- req_mem_rd_resp_dst_x/dst_y (in XY_WIDTH)
- req_mem_rd_resp_fbits (in NOC_FBITS_WIDTH)
- req_mem_rd_resp_mode (in 1): 0 = data-available, 1 = space-empty
REQ-010 Ports ptr_rd_req_val/rdy (out/in 1), ptr_rd_req_addr (out FLOWID_W), ptr_rd_resp_val (in 1), ptr_rd_resp_base/end (in POLLER_PTR_W+1): one request returns both pointers.
REQ-011 Port group msg_dst_* (output), valid/ready handshake:
- msg_dst_val (out 1), msg_dst_rdy (in 1)
- msg_dst_flowid, msg_dst_base_ptr (POLLER_PTR_W+1), msg_dst_len, msg_dst_dst_x/dst_y/fbits
REQ-012 Ports clr_val/rdy (out/in 1), clr_flowid (out FLOWID_W): active-bitvector clear.
REQ-013 Ports stat_polls, stat_hits (output STAT_W): total evaluations and satisfied evaluations.

Function
REQ-014 FSM states, one per cycle minimum: IDLE, REQ_RD, REQ_WAIT, PTR_RD, PTR_WAIT, EVAL, SEND, CLEAR, REQUEUE.
REQ-015 IDLE: when !q_empty, assert q_rd_en for one cycle, latch q_rd_data into flowid_reg, go to REQ_RD.
REQ-016 REQ_RD: assert req_mem_rd_req_val with addr=flowid_reg; on rdy go to REQ_WAIT.
REQ-017 REQ_WAIT: on resp_val, latch len/dst/fbits/mode, go to PTR_RD.
REQ-018 PTR_RD: assert ptr_rd_req_val with addr=flowid_reg; on rdy go to PTR_WAIT.
REQ-019 PTR_WAIT: on resp_val, latch base/end, go to EVAL.
REQ-020 Response valids arriving in any other state SHALL be ignored.
REQ-021 EVAL: compute all arithmetic modulo 2^(POLLER_PTR_W+1).
- mode 0: used = end - base; satisfied = used >= len.
- mode 1: used = base - end; empty = 2^POLLER_PTR_W - used; satisfied = empty >= len.
REQ-022 len = 0 SHALL always be satisfied.
REQ-023 EVAL SHALL increment stat_polls, and stat_hits when satisfied; counters wrap at 2^STAT_W.
REQ-024 EVAL transitions: satisfied -> SEND; otherwise -> REQUEUE.
REQ-025 SEND: hold msg_dst_val=1 with all fields stable (base_ptr = latched base) until msg_dst_rdy, then go to CLEAR.
REQ-026 CLEAR: hold clr_val=1, clr_flowid=flowid_reg until clr_rdy, then go to IDLE; the flow is not requeued.
REQ-027 REQUEUE: assert q_wr_en with q_wr_data=flowid_reg in the first cycle where !q_full, then go to IDLE; while q_full, stall with q_wr_en=0.
REQ-028 At most one flow SHALL be in flight; q_rd_en and q_wr_en are never asserted in the same cycle.
REQ-029 All valid outputs SHALL be registered or decoded from state only, never combinationally dependent on any rdy input.

Reset
REQ-030 On rst: state=IDLE, all val/en outputs 0, all latched registers 0, stat counters 0.
REQ-031 Reset mid-operation SHALL abandon the in-flight flow with no requeue or clear; re-arming is the owner's responsibility.

Verification
REQ-032 Mode 0, base=0x0010, end=0x0030, len=0x20 -> satisfied, msg_dst with base_ptr 0x0010, then clr_flowid, stat_hits=1.
REQ-033 Mode 0, base=0x1FFF0, end=0x00010 (wrapped, W=16), len=0x21 -> used=0x20, unsatisfied, q_wr_data=flowid, no msg_dst.
REQ-034 Mode 1, base=0x10005, end=0x00005 (full), len=1 -> empty=0, requeue; same with len=0 -> satisfied, msg_dst issued.
REQ-035 q_full held for 5 cycles in REQUEUE -> q_wr_en stays 0, then pulses exactly once after q_full deasserts.
REQ-036 msg_dst_rdy withheld for 10 cycles -> msg_dst_val and fields stable, stat_polls incremented once only.
REQ-037 rst asserted in PTR_WAIT, then a stale ptr_rd_resp_val arrives -> FSM stays IDLE, all outputs 0, counters 0.
